alu_op_decoder: RTL and testbench
=================================

# alu_op_decoder

ID-stage decoder that turns a 32-bit MIPS instruction word into the 6-bit ALU function code (`alu_fun`) and operand-select controls consumed by the EX-stage ALU, including the 4-bit logic-unit FT field. It registers its result into a one-entry ID/EX slot with a valid/ready handshake. It traps on illegal encodings and holds until the pipeline flushes.

## Interface
- `COUNT_W`, default 8: width of the saturating illegal-instruction counter.
- `clk` input 1: the block's only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: an instruction is presented.
- `in_instr` input 32: instruction word.
- `in_ready` output 1: the block accepts the instruction this cycle.
- `flush` input 1: squash the slot and leave TRAP.
- `out_valid` output 1: the slot holds a decoded instruction.
- `out_ready` input 1: the EX stage consumes the slot.
- `alu_fun` output 6: ALU function code.
- `sign_ext` output 1: the immediate is sign-extended (1) or zero-extended (0).
- `b_imm` output 1: ALU B operand is the immediate.
- `a_shamt` output 1: ALU A operand is `instr[10:6]`.
- `a_lui` output 1: ALU A operand is `{imm,16'b0}`.
- `illegal` output 1: the slot holds an illegal encoding.
- `illegal_count` output `COUNT_W`: number of illegal instructions accepted, saturating.

## Operation
- ALU function codes:
  - `ADD` 000000, `SUB` 000001
  - `AND` 011000, `OR` 011110, `XOR` 010110, `NOR` 010001, `PASSA` 011010
  - `SLL` 100000, `SRL` 100001, `SRA` 100011
  - `EQ` 110011, `NEQ` 110001, `LT` 110101, `LEZ` 111101, `LTZ` 111001, `GTZ` 111111
- R-type (opcode 0x00), decoded by funct:
  - 0x20/0x21 → `ADD`; 0x22/0x23 → `SUB`
  - 0x24 → `AND`; 0x25 → `OR`; 0x26 → `XOR`; 0x27 → `NOR`
  - 0x00 → `SLL`, 0x02 → `SRL`, 0x03 → `SRA`, each with `a_shamt`=1
  - 0x2a/0x2b → `LT`; 0x08 (jr) → `ADD`
- I-type, decoded by opcode:
  - 0x08/0x09 → `ADD`, `b_imm`, `sign_ext`
  - 0x0a → `LT`, `b_imm`, `sign_ext`
  - 0x0c → `AND`, 0x0d → `OR`, 0x0e → `XOR`; each with `b_imm` and zero-extended immediate
  - 0x0f → `PASSA`, `a_lui`
  - 0x23/0x2b → `ADD`, `b_imm`, `sign_ext`
  - 0x04 → `EQ`; 0x05 → `NEQ`; 0x06 → `LEZ`; 0x07 → `GTZ`; all with `sign_ext`
  - 0x01 with rt=0 → `LTZ`, `sign_ext`
  - 0x02/0x03 → `ADD`, all selects 0
- Any other opcode/funct combination is illegal. The slot is then loaded with `alu_fun`=`ADD`, all selects 0, `illegal`=1.
- FSM has two states, `RUN` and `TRAP`.
  - `RUN`: `in_ready = !flush && (!out_valid || out_ready)`.
  - `RUN` → `TRAP` when an illegal instruction is accepted.
  - `TRAP`: `in_ready`=0. The trapped slot is still presented until consumed, then `out_valid`=0.
  - `TRAP` → `RUN` only on `flush`.
- `flush`, in any state: next cycle `out_valid`=0 and state=`RUN`. An instruction presented in the same cycle is not accepted (`in_ready`=0).
- `illegal_count` increments by 1 on each accepted illegal instruction and saturates at 2^`COUNT_W`−1. Flush does not clear it.

## Timing
- Latency is one cycle: an accept at edge N makes `out_valid` and the decoded fields valid after edge N.
- Throughput is one instruction per cycle while `out_ready`=1. A consume and a new accept in the same cycle keep `out_valid`=1 with the new contents.
- While `out_valid`=1 and `out_ready`=0, all outputs hold stable.
- Reset (asynchronous, any time, including mid-transfer):
  - `out_valid`=0, `illegal`=0, `illegal_count`=0, state=`RUN`
  - `alu_fun`=000000, all selects 0
  - `in_ready` rises in the first cycle after `rst_n` deasserts.
- Decoded outputs are don't-care when `out_valid`=0. The bench checks them only when valid.

## Structure
- Shared package `alu_pkg`: the `ALU_*` function-code constants (the logic-unit FT codes are `alu_fun[3:0]` under prefix 01), the opcode and funct constants, and the `state_t` enum.
- One combinational sub-module, `alu_op_decode_comb`: instruction → {`alu_fun`, selects, `illegal`}.
- The top level holds the slot register, the FSM and the counter.

## Test plan
- Stream `add`, `ori`, `sll`, `beq` back-to-back with `out_ready`=1 → four consecutive valid cycles with `alu_fun` 000000, 011110, 100000, 110011; `ori` has `sign_ext`=0; `sll` has `a_shamt`=1.
- `lui` (0x3c01_1234) → `alu_fun`=011010, `a_lui`=1, `b_imm`=0.
- Hold `out_ready`=0 for 3 cycles after accepting `sub` → outputs stable, `in_ready`=0; on release, `sub` is consumed and the next instruction is accepted in the same cycle.
- Illegal word 0xfc00_0000 → `illegal`=1, `illegal_count`=1, `in_ready` stays 0 after consume; assert `flush` → next cycle `RUN`, `out_valid`=0, `in_ready`=1.
- Present 300 illegal instructions, each followed by a flush → `illegal_count` saturates at 255.
- Assert `rst_n`=0 while `out_valid`=1 in `TRAP` → outputs zero immediately; after release the block accepts `addi` and decodes `ADD`, `b_imm`=1, `sign_ext`=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU function codes, MIPS opcode/funct constants and decoder types.
// Logic-unit ops carry their 4-bit FT truth table in alu_fun[3:0] under prefix 01.
package alu_pkg;

  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_AND   = 6'b011000;
  localparam logic [5:0] ALU_OR    = 6'b011110;
  localparam logic [5:0] ALU_XOR   = 6'b010110;
  localparam logic [5:0] ALU_NOR   = 6'b010001;
  localparam logic [5:0] ALU_PASSA = 6'b011010;
  localparam logic [5:0] ALU_SLL   = 6'b100000;
  localparam logic [5:0] ALU_SRL   = 6'b100001;
  localparam logic [5:0] ALU_SRA   = 6'b100011;
  localparam logic [5:0] ALU_EQ    = 6'b110011;
  localparam logic [5:0] ALU_NEQ   = 6'b110001;
  localparam logic [5:0] ALU_LT    = 6'b110101;
  localparam logic [5:0] ALU_LEZ   = 6'b111101;
  localparam logic [5:0] ALU_LTZ   = 6'b111001;
  localparam logic [5:0] ALU_GTZ   = 6'b111111;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic {StRun, StTrap} state_t;

  typedef struct packed {
    logic [5:0] alu_fun;
    logic       sign_ext;
    logic       b_imm;
    logic       a_shamt;
    logic       a_lui;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_op_decode_comb.sv
// Combinational decode of a MIPS instruction word into ALU controls.
module alu_op_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];

  always_comb begin
    // Default doubles as the illegal payload: ADD with all selects clear.
    dec = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_JR: dec.alu_fun = ALU_ADD;
          FN_SUB, FN_SUBU:        dec.alu_fun = ALU_SUB;
          FN_AND:                 dec.alu_fun = ALU_AND;
          FN_OR:                  dec.alu_fun = ALU_OR;
          FN_XOR:                 dec.alu_fun = ALU_XOR;
          FN_NOR:                 dec.alu_fun = ALU_NOR;
          FN_SLT, FN_SLTU:        dec.alu_fun = ALU_LT;
          FN_SLL: begin dec.alu_fun = ALU_SLL; dec.a_shamt = 1'b1; end
          FN_SRL: begin dec.alu_fun = ALU_SRL; dec.a_shamt = 1'b1; end
          FN_SRA: begin dec.alu_fun = ALU_SRA; dec.a_shamt = 1'b1; end
          default:                dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        dec.alu_fun  = ALU_ADD;
        dec.b_imm    = 1'b1;
        dec.sign_ext = 1'b1;
      end
      OP_SLTI: begin
        dec.alu_fun  = ALU_LT;
        dec.b_imm    = 1'b1;
        dec.sign_ext = 1'b1;
      end
      OP_ANDI: begin dec.alu_fun = ALU_AND; dec.b_imm = 1'b1; end
      OP_ORI:  begin dec.alu_fun = ALU_OR;  dec.b_imm = 1'b1; end
      OP_XORI: begin dec.alu_fun = ALU_XOR; dec.b_imm = 1'b1; end
      OP_LUI:  begin dec.alu_fun = ALU_PASSA; dec.a_lui = 1'b1; end
      OP_BEQ:  begin dec.alu_fun = ALU_EQ;  dec.sign_ext = 1'b1; end
      OP_BNE:  begin dec.alu_fun = ALU_NEQ; dec.sign_ext = 1'b1; end
      OP_BLEZ: begin dec.alu_fun = ALU_LEZ; dec.sign_ext = 1'b1; end
      OP_BGTZ: begin dec.alu_fun = ALU_GTZ; dec.sign_ext = 1'b1; end
      OP_REGIMM: begin
        if (rt == 5'd0) begin
          dec.alu_fun  = ALU_LTZ;
          dec.sign_ext = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_J, OP_JAL: dec.alu_fun = ALU_ADD;
      default:      dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_decoder.sv
// ID-stage ALU op decoder with a one-entry ID/EX slot, illegal-op trap FSM
// and a saturating illegal-instruction counter.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [31:0]        in_instr,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [5:0]         alu_fun,
  output logic               sign_ext,
  output logic               b_imm,
  output logic               a_shamt,
  output logic               a_lui,
  output logic               illegal,
  output logic [COUNT_W-1:0] illegal_count
);

  dec_t               dec;
  dec_t               slot_q, slot_d;
  logic               valid_q, valid_d;
  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               accept;

  alu_op_decode_comb u_decode (
    .instr (in_instr),
    .dec   (dec)
  );

  assign in_ready = (state_q == StRun) && !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    state_d = state_q;
    count_d = count_q;
    if (flush) begin
      valid_d = 1'b0;
      state_d = StRun;
    end else if (accept) begin
      slot_d  = dec;
      valid_d = 1'b1;
      if (dec.illegal) begin
        state_d = StTrap;
        if (count_q != {COUNT_W{1'b1}}) count_d = count_q + 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
      state_q <= StRun;
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign out_valid     = valid_q;
  assign alu_fun       = slot_q.alu_fun;
  assign sign_ext      = slot_q.sign_ext;
  assign b_imm         = slot_q.b_imm;
  assign a_shamt       = slot_q.a_shamt;
  assign a_lui         = slot_q.a_lui;
  assign illegal       = slot_q.illegal;
  assign illegal_count = count_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: decode, backpressure, trap/flush,
// counter saturation and asynchronous reset during a trap.
module tb_alu_op_decoder;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_ORI  = 32'h3421_0005;
  localparam logic [31:0] I_SLL  = 32'h0001_1100;
  localparam logic [31:0] I_BEQ  = 32'h1022_0003;
  localparam logic [31:0] I_LUI  = 32'h3c01_1234;
  localparam logic [31:0] I_SUB  = 32'h0022_1822;
  localparam logic [31:0] I_ADDI = 32'h2001_0001;
  localparam logic [31:0] I_BLTZ = 32'h0420_0002;
  localparam logic [31:0] I_ILL  = 32'hfc00_0000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [5:0] alu_fun;
  logic       sign_ext, b_imm, a_shamt, a_lui, illegal;
  logic [7:0] illegal_count;

  int n_checks = 0;
  int n_pass   = 0;

  alu_op_decoder #(.COUNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_instr      (in_instr),
    .in_ready      (in_ready),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_fun       (alu_fun),
    .sign_ext      (sign_ext),
    .b_imm         (b_imm),
    .a_shamt       (a_shamt),
    .a_lui         (a_lui),
    .illegal       (illegal),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Checks every decoded field of a valid slot.
  task automatic check_slot(input string tag, input logic [5:0] fun, input logic se,
                            input logic bi, input logic sh, input logic lu, input logic il);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".fun"}, 32'(alu_fun), 32'(fun));
    check({tag, ".sel"}, {28'd0, sign_ext, b_imm, a_shamt, a_lui},
          {28'd0, se, bi, sh, lu});
    check({tag, ".ill"}, 32'(illegal), 32'(il));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
    #1;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.fun", 32'(alu_fun), 32'd0);
    check("rst.ill", {illegal_count, 7'd0, illegal}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream
    in_valid = 1'b1; in_instr = I_ADD;
    tick(); check_slot("add", 6'b000000, 0, 0, 0, 0, 0);
    in_instr = I_ORI;
    tick(); check_slot("ori", 6'b011110, 0, 1, 0, 0, 0);
    in_instr = I_SLL;
    tick(); check_slot("sll", 6'b100000, 0, 0, 1, 0, 0);
    in_instr = I_BEQ;
    tick(); check_slot("beq", 6'b110011, 1, 0, 0, 0, 0);
    in_instr = I_LUI;
    tick(); check_slot("lui", 6'b011010, 0, 0, 0, 1, 0);
    in_instr = I_BLTZ;
    tick(); check_slot("bltz", 6'b111001, 1, 0, 0, 0, 0);
    in_instr = I_SUB;
    tick(); check_slot("sub", 6'b000001, 0, 0, 0, 0, 0);

    // Backpressure: sub must hold while addi waits
    out_ready = 1'b0; in_instr = I_ADDI;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall.in_ready", 32'(in_ready), 32'd0);
      tick();
      check_slot("stall.sub", 6'b000001, 0, 0, 0, 0, 0);
    end
    out_ready = 1'b1;
    #1;
    check("release.in_ready", 32'(in_ready), 32'd1);
    tick(); check_slot("addi", 6'b000000, 1, 1, 0, 0, 0);

    // Illegal -> trap
    in_instr = I_ILL;
    tick(); check_slot("ill", 6'b000000, 0, 0, 0, 0, 1);
    check("ill.count", 32'(illegal_count), 32'd1);
    in_instr = I_ADD;
    #1;
    check("trap.in_ready", 32'(in_ready), 32'd0);
    tick();
    check("trap.consumed", 32'(out_valid), 32'd0);
    check("trap.in_ready2", 32'(in_ready), 32'd0);
    flush = 1'b1;
    #1;
    check("flush.in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush.valid", 32'(out_valid), 32'd0);
    check("flush.in_ready", 32'(in_ready), 32'd1);
    check("flush.count", 32'(illegal_count), 32'd1);

    // Saturation: 300 more illegal ops, each followed by a flush
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_instr = I_ILL;
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      if (i == 99) check("count.101", 32'(illegal_count), 32'd101);
    end
    check("count.sat", 32'(illegal_count), 32'd255);

    // Async reset while a trapped slot is presented
    in_valid = 1'b1; in_instr = I_ILL; out_ready = 1'b0;
    tick(); check_slot("trap2", 6'b000000, 0, 0, 0, 0, 1);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(out_valid), 32'd0);
    check("arst.ill", 32'(illegal), 32'd0);
    check("arst.count", 32'(illegal_count), 32'd0);
    check("arst.fun", {26'd0, alu_fun}, 32'd0);
    check("arst.sel", {28'd0, sign_ext, b_imm, a_shamt, a_lui}, 32'd0);
    #3 rst_n = 1'b1;
    in_valid = 1'b1; in_instr = I_ADDI; out_ready = 1'b1;
    #1;
    check("arst.in_ready", 32'(in_ready), 32'd1);
    tick(); check_slot("arst.addi", 6'b000000, 1, 1, 0, 0, 0);
    in_valid = 1'b0;
    tick();
    check("drain.valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
